// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, NOP encoding, PC increment, fetch FSM states.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam int          PC_INC           = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word when load is high.
// Latency: 1 cycle. Backpressure: load low holds contents; flush overrides load and hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            adel,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_valid,
  output logic            if_adel
);

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc    <= '0;
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
      if_adel  <= 1'b0;
    end else if (flush) begin
      // if_pc is left alone; only the payload and its qualifiers are squashed
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
      if_adel  <= 1'b0;
    end else if (load) begin
      if_pc    <= pc;
      if_inst  <= inst;
      if_valid <= 1'b1;
      if_adel  <= adel;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, pending redirect, IDLE/FETCH FSM; FETCH_ALIGN_CHECK_EN enables address-error capture.
// Latency: 1 cycle imem_addr -> if_inst. Backpressure: stall holds pc and IF/ID, latching any redirect as pending.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_ce,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_valid,
  output logic            if_adel
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, next_pc, tgt;
  logic [PC_W-1:0] pend_pc;
  logic            pend_valid;
  logic            fetch_en;
  logic            misalign;
  logic [31:0]     inst_in;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt      = redirect_pc;
  assign misalign = |pc[1:0];
`else
  assign tgt      = redirect_pc & ~PC_W'(3);
  assign misalign = 1'b0;
`endif

  assign fetch_en  = (state == FETCH) && !stall;
  assign imem_ce   = fetch_en && !misalign;
  assign imem_addr = pc;
  assign inst_in   = misalign ? NOP_INST : imem_data;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    next_pc = pc + PC_W'(PC_INC);
    if (redirect_valid)  next_pc = tgt;
    else if (pend_valid) next_pc = pend_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_en) begin
        pc         <= next_pc;
        pend_valid <= 1'b0;
      end else if (state == FETCH && redirect_valid) begin
        // stalled: remember the latest target until the stall releases
        pend_valid <= 1'b1;
        pend_pc    <= tgt;
      end
    end
  end

  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (fetch_en),
    .flush    (flush),
    .pc       (pc),
    .inst     (inst_in),
    .adel     (misalign),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .if_adel  (if_adel)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ce;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, if_adel;
  int          checks = 0;
  int          fails  = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'h0000_f025;
      32'h4:   mem = 32'h241d_1000;
      default: mem = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb imem_data = mem(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    checks++; if (imem_ce !== 1'b0) begin fails++; $display("FAIL rst_ce got %b exp 0", imem_ce); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if ({if_valid, if_adel, if_inst, if_pc} !== 66'h0) begin fails++;
      $display("FAIL rst_ifid got v=%b a=%b i=%h p=%h exp all 0", if_valid, if_adel, if_inst, if_pc); end
    rst = 0; #1;  // cycle 0
    checks++; if (imem_ce !== 1'b0) begin fails++; $display("FAIL cyc0_ce got %b exp 0", imem_ce); end
    tick();       // cycle 1
    checks++; if (imem_ce !== 1'b1 || imem_addr !== 32'h0) begin fails++;
      $display("FAIL cyc1 got ce=%b addr=%h exp ce=1 addr=0", imem_ce, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin fails++; $display("FAIL cyc1_valid got %b exp 0", if_valid); end
    tick();
    checks++; if (if_inst !== 32'h0000_f025 || if_pc !== 32'h0 || if_valid !== 1'b1) begin fails++;
      $display("FAIL first_fetch got i=%h p=%h v=%b exp 0000f025 0 1", if_inst, if_pc, if_valid); end
    tick();
    checks++; if (if_inst !== 32'h241d_1000 || if_pc !== 32'h4 || imem_addr !== 32'h8) begin fails++;
      $display("FAIL second_fetch got i=%h p=%h a=%h exp 241d1000 4 8", if_inst, if_pc, imem_addr); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 0;
    checks++; if (if_pc !== 32'h8 || if_inst !== 32'hA5A5_0008 || if_valid !== 1'b1) begin fails++;
      $display("FAIL delay_slot got p=%h i=%h v=%b exp 8 a5a50008 1", if_pc, if_inst, if_valid); end
    checks++; if (imem_addr !== 32'h20) begin fails++; $display("FAIL redir_addr got %h exp 20", imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h20 || imem_addr !== 32'h24) begin fails++;
      $display("FAIL redir_next got p=%h a=%h exp 20 24", if_pc, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1; #1;
    checks++; if (imem_ce !== 1'b0) begin fails++; $display("FAIL stall_ce got %b exp 0", imem_ce); end
    tick();
    redirect_valid = 1; redirect_pc = 32'h180;
    tick();
    redirect_pc = 32'h190;
    tick();
    checks++; if (if_pc !== 32'h20 || if_inst !== 32'hA5A5_0020 || imem_addr !== 32'h24) begin fails++;
      $display("FAIL stall_hold got p=%h i=%h a=%h exp 20 a5a50020 24", if_pc, if_inst, imem_addr); end
    stall = 0; redirect_valid = 0; #1;
    checks++; if (imem_ce !== 1'b1 || imem_addr !== 32'h24) begin fails++;
      $display("FAIL release got ce=%b a=%h exp 1 24", imem_ce, imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h190 || if_pc !== 32'h24) begin fails++;
      $display("FAIL pend_target got a=%h p=%h exp 190 24", imem_addr, if_pc); end
  endtask

  task automatic test_flush();
    flush = 1; stall = 1;
    tick();
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || imem_addr !== 32'h190) begin fails++;
      $display("FAIL flush_stall got v=%b i=%h a=%h exp 0 0 190", if_valid, if_inst, imem_addr); end
    flush = 0; stall = 0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h190 || imem_addr !== 32'h194) begin fails++;
      $display("FAIL after_flush got v=%b p=%h a=%h exp 1 190 194", if_valid, if_pc, imem_addr); end
    flush = 1;
    tick();
    flush = 0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h198) begin fails++;
      $display("FAIL flush_adv got v=%b a=%h exp 0 198", if_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_load got %h exp fffffffc", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h5A5A_FFFC) begin fails++;
      $display("FAIL wrap got a=%h p=%h i=%h exp 0 fffffffc 5a5afffc", imem_addr, if_pc, if_inst); end
  endtask

  task automatic test_align();
    redirect_valid = 1; redirect_pc = 32'h22;
    tick();
    redirect_valid = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (imem_addr !== 32'h22 || imem_ce !== 1'b0) begin fails++;
      $display("FAIL mis_fetch got a=%h ce=%b exp 22 0", imem_addr, imem_ce); end
    tick();
    checks++; if (if_adel !== 1'b1 || if_inst !== 32'h0 || if_valid !== 1'b1 || if_pc !== 32'h22) begin fails++;
      $display("FAIL adel got a=%b i=%h v=%b p=%h exp 1 0 1 22", if_adel, if_inst, if_valid, if_pc); end
    checks++; if (imem_addr !== 32'h26) begin fails++; $display("FAIL mis_next got %h exp 26", imem_addr); end
`else
    checks++; if (imem_addr !== 32'h20 || imem_ce !== 1'b1) begin fails++;
      $display("FAIL align_force got a=%h ce=%b exp 20 1", imem_addr, imem_ce); end
    tick();
    checks++; if (if_adel !== 1'b0 || if_pc !== 32'h20 || if_inst !== 32'hA5A5_0020) begin fails++;
      $display("FAIL no_adel got a=%b p=%h i=%h exp 0 20 a5a50020", if_adel, if_pc, if_inst); end
`endif
  endtask

  task automatic test_reset_pending();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h300;
    tick();
    rst = 1; redirect_valid = 0;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0 || imem_ce !== 1'b0) begin fails++;
      $display("FAIL midrst got v=%b a=%h ce=%b exp 0 0 0", if_valid, imem_addr, imem_ce); end
    rst = 0; stall = 0;
    tick(); tick();
    checks++; if (imem_addr !== 32'h4 || if_pc !== 32'h0) begin fails++;
      $display("FAIL pend_discard got a=%h p=%h exp 4 0", imem_addr, if_pc); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall();
    test_flush();
    test_wrap();
    test_align();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-issue MIPS pipeline. Holds the PC and drives the address and enable of the combinational instruction memory. Registers the returned word into the IF/ID pipeline register. Handles sequential advance, branch/jump redirects (MIPS delay-slot semantics), stall and flush from the hazard unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_W, 32, PC and memory address width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and IF/ID register
- flush  in  1  squash IF/ID contents (insert NOP)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_W  redirect target
- imem_ce  out  1  instruction memory enable
- imem_addr  out  PC_W  byte address to instruction memory, equals pc
- imem_data  in  32  instruction word, combinationally valid in the same cycle as imem_addr
- if_pc  out  PC_W  PC of the instruction in IF/ID
- if_inst  out  32  instruction in IF/ID
- if_valid  out  1  IF/ID holds a real instruction
- if_adel  out  1  address-error flag for the instruction in IF/ID

## Operation
- Reset is synchronous, active-high, on clk.
- States: IDLE, FETCH.
  - rst forces IDLE.
  - IDLE -> FETCH unconditionally on the next edge with rst low.
  - FETCH persists until rst.
- imem_ce = (state==FETCH) && !stall.
- imem_addr = pc at all times.
- Reset values:
  - pc=RESET_PC, if_pc=0, if_inst=0, if_valid=0, if_adel=0, imem_ce=0.
  - pend_valid=0, pend_pc=0, state=IDLE.
- FETCH, !stall, each edge:
  - if_inst<=imem_data, if_pc<=pc, if_valid<=1.
  - pc<=next_pc.
- next_pc priority:
  1. redirect_valid → redirect_pc.
  2. pend_valid → pend_pc (then clear pend_valid).
  3. Otherwise pc+4, modulo 2^PC_W (32'hFFFF_FFFC wraps to 0).
- Delay slot: the word fetched in the redirect cycle is captured normally. Redirect does not squash it; only flush does.
- Stall: pc, if_* hold their values.
  - redirect_valid during stall sets pend_valid<=1, pend_pc<=redirect_pc.
  - A later redirect during the same stall overwrites pend_pc.
- Stall release with simultaneous redirect_valid: the new redirect wins; pend_valid is cleared.
- flush: if_valid<=0, if_inst<=0, if_adel<=0 on the edge.
  - Flush has priority over stall for IF/ID.
  - Flush has no effect on pc or the pending redirect.
- flush and !stall together: pc still advances (the squashed slot is lost, not refetched).
- rst mid-stall or with a pending redirect: everything returns to reset values; the pending target is discarded.

## Timing
- Fetch latency: 1 cycle. The word at imem_addr in cycle N appears on if_inst after edge N.
- First fetch:
  - Cycle 0 is the first cycle with rst low: IDLE, ce=0.
  - Cycle 1: addr=RESET_PC, ce=1.
  - if_valid=1 after edge 1.
- Redirect asserted in cycle N (unstalled) → imem_addr=redirect_pc in cycle N+1.
- Redirect asserted during stall → target appears on imem_addr in the cycle after stall deasserts.
- Sustained throughput: one instruction per cycle while unstalled.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect target with pc[1:0]!=0 is loaded as-is.
  - That fetch drives imem_ce=0.
  - Captured as if_inst=0, if_valid=1, if_adel=1, if_pc=misaligned value.
  - The next PC is that value +4.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 on load.
  - if_adel is tied to 0.

## Structure
- Shared package cpu_pkg:
  - RESET_PC_DEFAULT.
  - NOP_INST (32'h0000_0000).
  - PC_INC (4).
  - Fetch state enum (IDLE, FETCH).
- One sub-module, if_id_reg: the IF/ID pipeline register with flush/stall priority.
- PC, pending-redirect logic and FSM stay in fetch_stage.

## Test plan
- Reset release, no stall, memory words 0x0000f025 at 0x0 and 0x241d1000 at 0x4 → cycle 0 ce=0; if_inst=0x0000f025, if_pc=0x0 after edge 1; 0x241d1000, if_pc=0x4 after edge 2.
- Redirect to 0x20 in the cycle pc=0x8 → delay slot at 0x8 captured with if_valid=1; next imem_addr=0x20.
- stall high 3 cycles, redirect to 0x180 in stall cycle 2, then 0x190 in stall cycle 3 → if_* held; ce=0; first address after release is 0x190.
- flush and stall together → if_valid=0, if_inst=0; pc unchanged.
- pc=0xFFFF_FFFC unstalled → next imem_addr=0x0.
- Redirect to 0x22:
  - With FETCH_ALIGN_CHECK_EN: if_adel=1, if_inst=0, then addr 0x26.
  - Without: addr 0x20, if_adel=0.
